// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 scancode constants and key-event field offsets
package ps2_pkg;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;
  localparam int         EV_EXT         = 9;
  localparam int         EV_BRK         = 8;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word-fall-through FIFO; a pop frees a slot for a push in the same cycle
module ps2_event_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      lvl_q, lvl_d;
  logic             do_push, do_pop;
  // pointer and level bookkeeping; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    empty   = lvl_q == '0;
    full    = lvl_q == (AW+1)'(DEPTH);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    lvl_d   = lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rdata   = mem_q[rd_q];
    level   = lvl_q;
  end
  // storage needs no reset: an empty FIFO never presents its contents as valid
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
  // control state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// ps2_keyboard_ctrl: PS/2 device-to-host receiver queuing raw scancodes or decoded key events
module ps2_keyboard_ctrl import ps2_pkg::*; #(
  parameter  int DEPTH       = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int FILTER_LEN  = 4,
  parameter  int TIMEOUT     = 50000,
  parameter  int RAW_MODE    = 0,
  localparam int OUT_W       = (RAW_MODE != 0) ? 8 : 10,
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [LW-1:0]    fifo_level,
  output logic             overflow,
  output logic             parity_err,
  output logic             frame_err,
  output logic             timeout_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_EVAL  = 2'd2;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                   filt_q, filt_d;
  logic [FW-1:0]          flt_cnt_q, flt_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic                   ext_q, ext_d, brk_q, brk_d;
  logic                   ovf_q, ovf_d, par_q, par_d, frm_q, frm_d, to_q, to_d;
  logic                   sclk, sdata, flt_hit, fall, tmo, good, pfx, push, full, empty, pop_ok, drop;
  logic [1:0]             state;
  logic [10:0]            frame;
  logic [7:0]             code;
  logic [9:0]             ev;
  logic [OUT_W-1:0]       wdata;
  // synchronise both pins and debounce the clock; a fall is the cycle the filtered clock drops
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    sclk        = clk_sync_q[SYNC_STAGES-1];
    sdata       = data_sync_q[SYNC_STAGES-1];
    flt_hit     = (sclk != filt_q) && (flt_cnt_q == FW'(FILTER_LEN - 1));
    flt_cnt_d   = (sclk == filt_q || flt_hit) ? '0 : flt_cnt_q + FW'(1);
    filt_d      = flt_hit ? sclk : filt_q;
    fall        = flt_hit & ~sclk;
  end
  // frame FSM, watchdog and prefix decoder; the 11th bit is judged in the cycle it arrives
  always_comb begin
    frame     = {sdata, shift_q};
    code      = frame[8:1];
    state     = (fall && bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) ? ST_EVAL : (bit_cnt_q == '0) ? ST_IDLE : ST_SHIFT;
    tmo       = (state == ST_SHIFT) && !fall && (wd_q == WW'(TIMEOUT - 1));
    good      = (state == ST_EVAL) && !frame[0] && frame[10] && ^frame[9:1];
    pfx       = (code == PS2_EXT) || (code == PS2_BRK);
    push      = good && (RAW_MODE != 0 || !pfx);
    bit_cnt_d = (state == ST_EVAL || tmo) ? '0 : fall ? bit_cnt_q + 4'd1 : bit_cnt_q;
    shift_d   = fall ? {sdata, shift_q[9:1]} : shift_q;
    wd_d      = (state != ST_SHIFT || fall || tmo) ? '0 : wd_q + WW'(1);
    ext_d     = (tmo || (state == ST_EVAL && !(good && pfx))) ? 1'b0 : (good && code == PS2_EXT) ? 1'b1 : ext_q;
    brk_d     = (tmo || (state == ST_EVAL && !(good && pfx))) ? 1'b0 : (good && code == PS2_BRK) ? 1'b1 : brk_q;
    ev         = '0;
    ev[EV_EXT] = ext_q;
    ev[EV_BRK] = brk_q;
    ev[7:0]    = code;
    wdata      = OUT_W'(ev);
  end
  // sticky status: a new event wins over a clear arriving in the same cycle
  always_comb begin
    pop_ok = out_ready & ~empty;
    drop   = push & full & ~pop_ok;
    ovf_d  = drop | (ovf_q & ~clear);
    par_d  = (state == ST_EVAL && !(^frame[9:1])) | (par_q & ~clear);
    frm_d  = (state == ST_EVAL && (frame[0] || !frame[10])) | (frm_q & ~clear);
    to_d   = tmo | (to_q & ~clear);
  end
  // all receiver state; synchronisers and filter reset to the idle-high line level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      flt_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wd_q        <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      ovf_q       <= 1'b0;
      par_q       <= 1'b0;
      frm_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      flt_cnt_q   <= flt_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wd_q        <= wd_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      ovf_q       <= ovf_d;
      par_q       <= par_d;
      frm_q       <= frm_d;
      to_q        <= to_d;
    end
  ps2_event_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (out_ready),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  assign out_valid   = ~empty;
  assign overflow    = ovf_q;
  assign parity_err  = par_q;
  assign frame_err   = frm_q;
  assign timeout_err = to_q;
endmodule
